player_input_cond: RTL and testbench

// - Upstream conditioner for the player movement controller. Takes the raw asynchronous

---
 rtl/player_input_cond.sv | 217 +++++++++++++++++++++
 tb/tb_player_input_cond.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_input_cond.sv
// ---------------------------------------------------------------------------
// player_input_cond
// Input conditioner for the player movement controller. Brings the raw
// asynchronous direction lines and pressure plates into the clk domain,
// debounces each one, suppresses contradictory left+right commands and
// produces a one-clock frame tick from VGA vsync.
//
// Ports
//   clk             in   1  system/pixel clock
//   rst             in   1  synchronous reset, active-high
//   gpio_left_raw   in   1  async, active-high, player 2 left
//   gpio_right_raw  in   1  async, active-high, player 2 right
//   btn_raw         in   2  async, active-high, pressure plates [1:0]
//   vsync           in   1  VGA vsync (already in the clk domain)
//   gpio_left       out  1  debounced left, masked by the conflict rule
//   gpio_right      out  1  debounced right, masked by the conflict rule
//   button_pressed  out  2  debounced plates, unmasked
//   v_tick          out  1  one-clock pulse per frame
//
// Parameters
//   DEBOUNCE_CYCLES  stable sync cycles needed to accept a new level (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   VSYNC_ACT        active level of vsync; the tick fires entering it
//
// Build option
//   PLAYER_IN_FRAME_SYNC_EN  when defined, gpio_left/gpio_right/button_pressed
//                            reload only while v_tick is high and hold for
//                            the rest of the frame.
// ---------------------------------------------------------------------------
module player_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = 20,
  parameter logic        VSYNC_ACT       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gpio_left_raw,
  input  logic       gpio_right_raw,
  input  logic [1:0] btn_raw,
  input  logic       vsync,
  output logic       gpio_left,
  output logic       gpio_right,
  output logic [1:0] button_pressed,
  output logic       v_tick
);

  // Channel order: 0 left, 1 right, 2 plate 0, 3 plate 1.
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_L   = 0;
  localparam int unsigned CH_R   = 1;
  localparam int unsigned CH_B0  = 2;
  localparam int unsigned CH_B1  = 3;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } deb_state_e;

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] deb_lvl;

  assign raw_vec = {btn_raw[1], btn_raw[0], gpio_right_raw, gpio_left_raw};

  // Two-flop synchroniser for every async input.
  always_comb begin
    sync1_d = raw_vec;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Per-channel debounce FSM; the counter restarts on every bounce.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_deb
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             sync_bit;

    assign sync_bit = sync2_q[ch];
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Entering RISE/FALL counts as the first stable cycle, so the level is
    // accepted on the cycle the incremented count reaches DEBOUNCE_CYCLES.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_LOW: begin
          if (sync_bit) begin
            state_d = ST_RISE;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RISE: begin
          if (!sync_bit) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        ST_HIGH: begin
          if (!sync_bit) begin
            state_d = ST_FALL;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_FALL: begin
          if (sync_bit) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    assign deb_lvl[ch] = (state_q == ST_HIGH) || (state_q == ST_FALL);
  end

  // Frame tick: one pulse on the transition into the active vsync level.
  logic vs_q, vs_d;
  logic v_tick_q, v_tick_d;

  always_comb begin
    vs_d     = vsync;
    v_tick_d = (vs_q != VSYNC_ACT) && (vsync == VSYNC_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= ~VSYNC_ACT;
      v_tick_q <= 1'b0;
    end else begin
      vs_q     <= vs_d;
      v_tick_q <= v_tick_d;
    end
  end

  // Conflict masking: both directions asserted means neither is reported.
  logic       masked_l, masked_r;
  logic       left_q, left_d;
  logic       right_q, right_d;
  logic [1:0] btn_q, btn_d;

  assign masked_l = deb_lvl[CH_L] & ~deb_lvl[CH_R];
  assign masked_r = deb_lvl[CH_R] & ~deb_lvl[CH_L];

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    btn_d   = btn_q;
`ifdef PLAYER_IN_FRAME_SYNC_EN
    // Reload only on the frame tick so the consumer sees per-frame values.
    if (v_tick_q) begin
      left_d  = masked_l;
      right_d = masked_r;
      btn_d   = {deb_lvl[CH_B1], deb_lvl[CH_B0]};
    end
`else
    left_d  = masked_l;
    right_d = masked_r;
    btn_d   = {deb_lvl[CH_B1], deb_lvl[CH_B0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      btn_q   <= '0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      btn_q   <= btn_d;
    end
  end

  assign gpio_left      = left_q;
  assign gpio_right     = right_q;
  assign button_pressed = btn_q;
  assign v_tick         = v_tick_q;

endmodule

// File: tb/tb_player_input_cond.sv
// Bench for player_input_cond with DEBOUNCE_CYCLES=4, VSYNC_ACT=0.
// A sliding-window model predicts every output each cycle; directed
// literal checks pin the latencies of the model itself.
module tb_player_input_cond;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       gpio_left_raw, gpio_right_raw;
  logic [1:0] btn_raw;
  logic       vsync;
  logic       gpio_left, gpio_right;
  logic [1:0] button_pressed;
  logic       v_tick;

  int checks = 0;
  int errors = 0;

  player_input_cond #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .VSYNC_ACT      (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_left_raw (gpio_left_raw),
    .gpio_right_raw(gpio_right_raw),
    .btn_raw       (btn_raw),
    .vsync         (vsync),
    .gpio_left     (gpio_left),
    .gpio_right    (gpio_right),
    .button_pressed(button_pressed),
    .v_tick        (v_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Model: a channel flips its accepted level once the last D synchronised
  // samples all disagree with it. Synchroniser is a 2-deep delay line.
  logic          mvalid = 1'b0;
  logic [3:0]    ms1, ms2, mdeb;
  logic [D-1:0]  mh [4];
  logic          m_left, m_right, m_vt, mvs;
  logic [1:0]    m_btn;
  logic          ml, mr;

  always @(posedge clk) begin
    mvalid = 1'b1;
    if (rst) begin
      ms1 = '0; ms2 = '0; mdeb = '0;
      for (int c = 0; c < 4; c++) mh[c] = '0;
      m_left = 0; m_right = 0; m_btn = '0; m_vt = 0; mvs = 1'b1;
    end else begin
      ml = mdeb[0] & ~mdeb[1];
      mr = mdeb[1] & ~mdeb[0];
`ifdef PLAYER_IN_FRAME_SYNC_EN
      if (m_vt) begin
        m_left = ml; m_right = mr; m_btn = mdeb[3:2];
      end
`else
      m_left = ml; m_right = mr; m_btn = mdeb[3:2];
`endif
      m_vt = mvs && !vsync;
      for (int c = 0; c < 4; c++) begin
        mh[c] = {mh[c][D-2:0], ms2[c]};
        if (mh[c] == {D{~mdeb[c]}}) mdeb[c] = ~mdeb[c];
      end
      ms2 = ms1;
      ms1 = {btn_raw, gpio_right_raw, gpio_left_raw};
      mvs = vsync;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_gpio_left", {1'b0, gpio_left}, {1'b0, m_left});
      chk("model_gpio_right", {1'b0, gpio_right}, {1'b0, m_right});
      chk("model_button", button_pressed, m_btn);
      chk("model_v_tick", {1'b0, v_tick}, {1'b0, m_vt});
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; gpio_left_raw = 1'b1; gpio_right_raw = 1'b1;
    btn_raw = 2'b11; vsync = 1'b0;

    // Reset held 3 clk with all raw inputs high.
    for (int i = 0; i < 3; i++) begin
      wait_n(1);
      chk("rst_outputs", {gpio_left, gpio_right}, 2'b00);
      chk("rst_button", button_pressed, 2'b00);
      chk("rst_v_tick", {1'b0, v_tick}, 2'b00);
    end
    rst = 1'b0; vsync = 1'b1;
    wait_n(1);
    chk("post_rst_v_tick", {1'b0, v_tick}, 2'b00);

`ifndef PLAYER_IN_FRAME_SYNC_EN
    // Inputs held high through reset qualify afterwards; left/right conflict.
    wait_n(9);
    chk("held_conflict", {gpio_left, gpio_right}, 2'b00);
    chk("held_buttons", button_pressed, 2'b11);
    gpio_left_raw = 0; gpio_right_raw = 0; btn_raw = 2'b00;
    wait_n(10);
    chk("all_released", {gpio_left, gpio_right, button_pressed}, 2'b00);

    // Clean press and release of right.
    gpio_right_raw = 1'b1;
    wait_n(6); chk("right_press_6", {1'b0, gpio_right}, 2'b00);
    wait_n(1); chk("right_press_7", {1'b0, gpio_right}, 2'b01);
    wait_n(5);
    gpio_right_raw = 1'b0;
    wait_n(6); chk("right_rel_6", {1'b0, gpio_right}, 2'b01);
    wait_n(1); chk("right_rel_7", {1'b0, gpio_right}, 2'b00);
    wait_n(3);

    // Bouncing plate 0.
    btn_raw[0] = 1'b1; wait_n(1);
    btn_raw[0] = 1'b0; wait_n(1);
    btn_raw[0] = 1'b1; wait_n(1);
    btn_raw[0] = 1'b0; wait_n(1);
    chk("bounce_low", button_pressed, 2'b00);
    btn_raw[0] = 1'b1;
    wait_n(6); chk("bounce_6", button_pressed, 2'b00);
    wait_n(1); chk("bounce_7", button_pressed, 2'b01);
    btn_raw[0] = 1'b0;
    wait_n(10);

    // Conflict then right released.
    gpio_left_raw = 1'b1; gpio_right_raw = 1'b1;
    wait_n(10); chk("conflict_both", {gpio_left, gpio_right}, 2'b00);
    gpio_right_raw = 1'b0;
    wait_n(6); chk("conflict_6", {gpio_left, gpio_right}, 2'b00);
    wait_n(1); chk("conflict_7", {gpio_left, gpio_right}, 2'b10);
    gpio_left_raw = 1'b0;
    wait_n(10);

    // Reset mid-debounce forces full re-qualification.
    gpio_left_raw = 1'b1;
    wait_n(4);
    rst = 1'b1; wait_n(1);
    rst = 1'b0;
    wait_n(6); chk("rst_mid_6", {1'b0, gpio_left}, 2'b00);
    wait_n(1); chk("rst_mid_7", {1'b0, gpio_left}, 2'b01);
    gpio_left_raw = 1'b0;
    wait_n(10);

    // Vsync falling edge gives exactly one tick; rising edge none.
    vsync = 1'b0;
    wait_n(1); chk("vtick_fall_1", {1'b0, v_tick}, 2'b01);
    wait_n(1); chk("vtick_fall_2", {1'b0, v_tick}, 2'b00);
    wait_n(8); chk("vtick_held", {1'b0, v_tick}, 2'b00);
    vsync = 1'b1;
    wait_n(1); chk("vtick_rise_1", {1'b0, v_tick}, 2'b00);
    wait_n(1); chk("vtick_rise_2", {1'b0, v_tick}, 2'b00);
`else
    // Frame-synchronised outputs: nothing changes without a tick.
    gpio_left_raw = 0; gpio_right_raw = 0; btn_raw = 2'b00;
    wait_n(10);
    vsync = 1'b0; wait_n(2); vsync = 1'b1; wait_n(2);
    gpio_left_raw = 1'b1;
    wait_n(12);
    chk("fs_left_hold", {1'b0, gpio_left}, 2'b00);
    vsync = 1'b0;
    wait_n(1); chk("fs_tick", {1'b0, v_tick}, 2'b01);
    wait_n(1); chk("fs_left_load", {1'b0, gpio_left}, 2'b01);
    vsync = 1'b1;
    gpio_left_raw = 1'b0;
    wait_n(12);
    chk("fs_left_held", {1'b0, gpio_left}, 2'b01);
`endif

    // Simultaneous activity across channels and vsync, checked by the model.
    begin
      logic [5:0] pat [8];
      int         hold [8];
      pat[0] = 6'b1_0101_0; hold[0] = 3;
      pat[1] = 6'b0_1010_1; hold[1] = 7;
      pat[2] = 6'b1_1111_1; hold[2] = 5;
      pat[3] = 6'b0_0110_0; hold[3] = 9;
      pat[4] = 6'b1_1001_1; hold[4] = 2;
      pat[5] = 6'b0_0011_0; hold[5] = 8;
      pat[6] = 6'b1_0000_1; hold[6] = 4;
      pat[7] = 6'b1_0000_0; hold[7] = 10;
      for (int i = 0; i < 8; i++) begin
        vsync          = pat[i][5];
        btn_raw        = pat[i][4:3];
        gpio_right_raw = pat[i][2];
        gpio_left_raw  = pat[i][1];
        wait_n(hold[i]);
      end
      vsync = 1'b1;
      wait_n(10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
